// File: rtl/speed_round_ctrl_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : speed_round_ctrl_pkg
// Brief   : Shared state encoding and result codes for the speed-round sequencer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
package speed_round_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_COUNT  = 3'd2,
        ST_ROUND  = 3'd3,
        ST_SETTLE = 3'd4,
        ST_RESULT = 3'd5,
        ST_EXIT   = 3'd6
    } state_t;

    localparam logic [1:0] c_RES_NONE  = 2'b00;
    localparam logic [1:0] c_RES_LEFT  = 2'b01;
    localparam logic [1:0] c_RES_RIGHT = 2'b10;
    localparam logic [1:0] c_RES_TIE   = 2'b11;

    // A tie outranks right so that a simultaneous tie/right flag reads as a tie.
    function automatic logic [1:0] sample_result(input logic tie, input logic right);
        logic [1:0] res;
        if (tie) begin
            res = c_RES_TIE;
        end else if (right) begin
            res = c_RES_RIGHT;
        end else begin
            res = c_RES_LEFT;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/speed_round_ctrl_tick_down_counter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tick_down_counter
// Brief   : Loadable tick-enabled down-counter that saturates at zero.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module tick_down_counter #(
    parameter int TW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic [TW-1:0] i_load_value,
    input  logic          i_tick,
    output logic [TW-1:0] o_value,
    output logic [TW-1:0] o_value_nxt,
    output logic          o_zero
);

    logic [TW-1:0] r_value;
    logic [TW-1:0] w_value_nxt;

    always_comb begin
        w_value_nxt = r_value;
        if (i_load) begin
            w_value_nxt = i_load_value;
        end else if (i_tick && (r_value != '0)) begin
            w_value_nxt = r_value - TW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_value <= '0;
        end else begin
            r_value <= w_value_nxt;
        end
    end

    assign o_value     = r_value;
    assign o_value_nxt = w_value_nxt;
    assign o_zero      = (r_value == '0);

endmodule
`default_nettype wire

// File: rtl/speed_round_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : speed_round_ctrl
// Brief   : Tug-of-War speed-round sequencer: countdown, push window, settle,
//           sample and one-shot result publication.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module speed_round_ctrl
    import speed_round_ctrl_pkg::*;
#(
    parameter int COUNT_TICKS  = 3,
    parameter int ROUND_TICKS  = 5,
    parameter int RESULT_TICKS = 2,
    parameter int SETTLE_CYC   = 4,
    parameter int TW           = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic       abort,
    input  logic       speed_right,
    input  logic       speed_tie,
    output logic       speedRound,
    output logic       speedExit,
    output logic [3:0] countdown,
    output logic [1:0] result,
    output logic       result_valid,
    output logic       busy
);

    localparam int              c_SW          = $clog2(SETTLE_CYC + 1);
    localparam logic [c_SW-1:0] c_SETTLE_LAST = c_SW'(SETTLE_CYC - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [c_SW-1:0] r_settle_cnt;

    logic            w_ld;
    logic [TW-1:0]   w_ld_val;
    logic            w_tick_en;
    logic [TW-1:0]   w_tval;
    logic [TW-1:0]   w_tval_nxt;
    logic            w_tzero;
    logic            w_phase_done;
    logic            w_settle_done;
    logic            w_tick_phase;

    assign w_tick_phase  = (r_state == ST_COUNT) || (r_state == ST_ROUND) ||
                           (r_state == ST_RESULT);
    assign w_tick_en     = tick && w_tick_phase;
    // A zero counter in a tick phase only arises from a zero-length parameter; fall through.
    assign w_phase_done  = w_tzero || (tick && (w_tval == TW'(1)));
    assign w_settle_done = (r_state == ST_SETTLE) && (r_settle_cnt == c_SETTLE_LAST);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (start)         w_state_nxt = ST_CLEAR;
            ST_CLEAR:                     w_state_nxt = ST_COUNT;
            ST_COUNT:  if (w_phase_done)  w_state_nxt = ST_ROUND;
            ST_ROUND:  if (w_phase_done)  w_state_nxt = ST_SETTLE;
            ST_SETTLE: if (w_settle_done) w_state_nxt = ST_RESULT;
            ST_RESULT: if (w_phase_done)  w_state_nxt = ST_EXIT;
            ST_EXIT:                      w_state_nxt = ST_IDLE;
            default:                      w_state_nxt = ST_IDLE;
        endcase
        if (abort && (r_state != ST_IDLE) && (r_state != ST_EXIT)) begin
            w_state_nxt = ST_EXIT;
        end
    end

    // The tick counter is reloaded only on entry to a tick-timed phase.
    always_comb begin
        w_ld     = 1'b0;
        w_ld_val = '0;
        if (w_state_nxt != r_state) begin
            case (w_state_nxt)
                ST_COUNT:  begin w_ld = 1'b1; w_ld_val = TW'(COUNT_TICKS);  end
                ST_ROUND:  begin w_ld = 1'b1; w_ld_val = TW'(ROUND_TICKS);  end
                ST_RESULT: begin w_ld = 1'b1; w_ld_val = TW'(RESULT_TICKS); end
                default:   begin w_ld = 1'b0; w_ld_val = '0;                end
            endcase
        end
    end

    tick_down_counter #(
        .TW (TW)
    ) u_tick_ctr (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_ld),
        .i_load_value (w_ld_val),
        .i_tick       (w_tick_en),
        .o_value      (w_tval),
        .o_value_nxt  (w_tval_nxt),
        .o_zero       (w_tzero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_settle_cnt <= '0;
        end else if (r_state == ST_SETTLE) begin
            r_settle_cnt <= r_settle_cnt + c_SW'(1);
        end else begin
            r_settle_cnt <= '0;
        end
    end

    // Outputs are registered from the next state so they change together with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            speedRound   <= 1'b0;
            speedExit    <= 1'b0;
            countdown    <= 4'd0;
            result       <= c_RES_NONE;
            result_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            speedRound   <= (w_state_nxt == ST_ROUND);
            speedExit    <= (w_state_nxt == ST_CLEAR) || (w_state_nxt == ST_EXIT);
            countdown    <= (w_state_nxt == ST_COUNT) ? 4'(w_tval_nxt) : 4'd0;
            result_valid <= (r_state == ST_SETTLE) && (w_state_nxt == ST_RESULT);
            busy         <= (w_state_nxt != ST_IDLE);
            if (w_state_nxt == ST_RESULT) begin
                if (r_state == ST_SETTLE) begin
                    result <= sample_result(speed_tie, speed_right);
                end
            end else begin
                result <= c_RES_NONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_speed_round_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_speed_round_ctrl
// Brief   : Self-checking bench for speed_round_ctrl (vector table, directed
//           sequences and randomized traffic against a phase-level model).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module tb_speed_round_ctrl;

    localparam int COUNT_TICKS  = 3;
    localparam int ROUND_TICKS  = 5;
    localparam int RESULT_TICKS = 2;
    localparam int SETTLE_CYC   = 4;
    localparam int TW           = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick, start, abort, speed_right, speed_tie;
    logic       speedRound, speedExit, result_valid, busy;
    logic [3:0] countdown;
    logic [1:0] result;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    speed_round_ctrl #(
        .COUNT_TICKS  (COUNT_TICKS),
        .ROUND_TICKS  (ROUND_TICKS),
        .RESULT_TICKS (RESULT_TICKS),
        .SETTLE_CYC   (SETTLE_CYC),
        .TW           (TW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .start        (start),
        .abort        (abort),
        .speed_right  (speed_right),
        .speed_tie    (speed_tie),
        .speedRound   (speedRound),
        .speedExit    (speedExit),
        .countdown    (countdown),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy)
    );

    // Phase-level reference model
    typedef enum int {M_IDLE, M_CLEAR, M_COUNT, M_ROUND, M_SETTLE, M_RESULT, M_EXIT} mphase_t;
    mphase_t    m_phase;
    int         m_left;
    int         m_settle;
    logic [1:0] m_res;
    bit         m_valid;

    task automatic model_reset();
        m_phase  = M_IDLE;
        m_left   = 0;
        m_settle = 0;
        m_res    = 2'b00;
        m_valid  = 1'b0;
    endtask

    task automatic model_step(input bit t, input bit s, input bit a, input bit r, input bit ti);
        m_valid = 1'b0;
        if (a && m_phase != M_IDLE && m_phase != M_EXIT) begin
            m_phase = M_EXIT;
        end else begin
            case (m_phase)
                M_IDLE:  if (s) m_phase = M_CLEAR;
                M_CLEAR: begin m_phase = M_COUNT; m_left = COUNT_TICKS; end
                M_COUNT: if (t) begin
                    if (m_left == 1) begin m_phase = M_ROUND; m_left = ROUND_TICKS; end
                    else m_left--;
                end
                M_ROUND: if (t) begin
                    if (m_left == 1) begin m_phase = M_SETTLE; m_settle = 0; end
                    else m_left--;
                end
                M_SETTLE: begin
                    m_settle++;
                    if (m_settle == SETTLE_CYC) begin
                        m_phase = M_RESULT;
                        m_left  = RESULT_TICKS;
                        m_valid = 1'b1;
                        m_res   = ti ? 2'b11 : (r ? 2'b10 : 2'b01);
                    end
                end
                M_RESULT: if (t) begin
                    if (m_left == 1) m_phase = M_EXIT;
                    else m_left--;
                end
                default: m_phase = M_IDLE;
            endcase
        end
    endtask

    function automatic logic [9:0] model_vec();
        return {m_phase == M_ROUND,
                (m_phase == M_CLEAR) || (m_phase == M_EXIT),
                (m_phase == M_COUNT) ? 4'(m_left) : 4'd0,
                (m_phase == M_RESULT) ? m_res : 2'b00,
                m_valid,
                m_phase != M_IDLE};
    endfunction

    function automatic logic [9:0] dut_vec();
        return {speedRound, speedExit, countdown, result, result_valid, busy};
    endfunction

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (sr,se,cd,res,rv,busy)", name, act, exp);
        end
    endtask

    task automatic cyc(input bit t, input bit s, input bit a, input bit r, input bit ti);
        tick = t; start = s; abort = a; speed_right = r; speed_tie = ti;
        @(posedge clk);
        #1;
        model_step(t, s, a, r, ti);
        check("model", dut_vec(), model_vec());
    endtask

    typedef struct {
        bit         t, s, a, r, ti;
        logic [9:0] exp;
    } vec_t;

    function automatic vec_t mk(input bit t, input bit s, input bit r,
                                input bit sr, input bit se, input logic [3:0] cd,
                                input logic [1:0] res, input bit rv, input bit bz);
        vec_t v;
        v.t = t; v.s = s; v.a = 1'b0; v.r = r; v.ti = 1'b0;
        v.exp = {sr, se, cd, res, rv, bz};
        return v;
    endfunction

    task automatic full_round(input bit r, input bit ti, input logic [1:0] want, input string name);
        bit seen;
        seen = 1'b0;
        cyc(1, 1, 0, 0, 0);
        for (int k = 0; k < 60 && busy; k++) begin
            cyc(1, 0, 0, r, ti);
            if (result_valid) begin
                seen = 1'b1;
                check(name, {8'd0, result}, {8'd0, want});
            end
        end
        check({name, "_strobe"}, {9'd0, seen}, 10'd1);
        check({name, "_idle"}, {9'd0, busy}, 10'd0);
    endtask

    task automatic reach_round();
        cyc(0, 1, 0, 0, 0);
        for (int k = 0; k < 30 && !speedRound; k++) begin
            cyc(1, 0, 0, 0, 0);
        end
        check("reach_round", {9'd0, speedRound}, 10'd1);
    endtask

    vec_t tbl [17];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        tick = 0; start = 0; abort = 0; speed_right = 0; speed_tie = 0;
        model_reset();

        // Full round with a tick on every cycle; start pulses in COUNT/ROUND are ignored.
        tbl[0]  = mk(1, 1, 0,  0, 1, 4'd0, 2'b00, 0, 1);
        tbl[1]  = mk(1, 0, 0,  0, 0, 4'd3, 2'b00, 0, 1);
        tbl[2]  = mk(1, 1, 0,  0, 0, 4'd2, 2'b00, 0, 1);
        tbl[3]  = mk(1, 0, 0,  0, 0, 4'd1, 2'b00, 0, 1);
        tbl[4]  = mk(1, 0, 0,  1, 0, 4'd0, 2'b00, 0, 1);
        tbl[5]  = mk(1, 0, 0,  1, 0, 4'd0, 2'b00, 0, 1);
        tbl[6]  = mk(1, 1, 0,  1, 0, 4'd0, 2'b00, 0, 1);
        tbl[7]  = mk(1, 0, 0,  1, 0, 4'd0, 2'b00, 0, 1);
        tbl[8]  = mk(1, 0, 0,  1, 0, 4'd0, 2'b00, 0, 1);
        tbl[9]  = mk(1, 0, 0,  0, 0, 4'd0, 2'b00, 0, 1);
        tbl[10] = mk(1, 0, 0,  0, 0, 4'd0, 2'b00, 0, 1);
        tbl[11] = mk(0, 0, 0,  0, 0, 4'd0, 2'b00, 0, 1);
        tbl[12] = mk(0, 1, 0,  0, 0, 4'd0, 2'b00, 0, 1);
        tbl[13] = mk(1, 0, 1,  0, 0, 4'd0, 2'b10, 1, 1);
        tbl[14] = mk(1, 0, 0,  0, 0, 4'd0, 2'b10, 0, 1);
        tbl[15] = mk(1, 0, 0,  0, 1, 4'd0, 2'b00, 0, 1);
        tbl[16] = mk(0, 0, 0,  0, 0, 4'd0, 2'b00, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        check("reset", dut_vec(), 10'd0);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            tick = tbl[i].t; start = tbl[i].s; abort = tbl[i].a;
            speed_right = tbl[i].r; speed_tie = tbl[i].ti;
            @(posedge clk);
            #1;
            model_step(tbl[i].t, tbl[i].s, tbl[i].a, tbl[i].r, tbl[i].ti);
            check($sformatf("table[%0d]", i), dut_vec(), tbl[i].exp);
        end

        full_round(1, 1, 2'b11, "tie_over_right");
        full_round(0, 0, 2'b01, "left_win");
        full_round(1, 0, 2'b10, "right_win");

        // Abort in the middle of the push window.
        reach_round();
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0);
        check("abort_exit", {speedRound, speedExit, countdown, result, result_valid, busy},
              10'b01_0000_00_0_1);
        cyc(1, 0, 0, 0, 0);
        check("abort_idle", {9'd0, busy}, 10'd0);

        // Asynchronous reset between clock edges while the window is open.
        reach_round();
        tick = 0; start = 0; abort = 0;
        #2;
        rst = 1'b1;
        #1;
        check("rst_async", {7'd0, speedRound, speedExit, result_valid}, 10'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_idle", dut_vec(), 10'd0);
        cyc(0, 0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 3) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
